// File: rtl/dtc_inverse_search_if.sv
// Target/result handshake bundle for dtc_inverse_search.
// slave = search block, master = requester driving targets and consuming results.
interface dtc_inverse_search_if;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [7:0] tgt_code;
   logic       tgt_cont;
   logic       abort;
   logic       res_valid;
   logic       res_ready;
   logic       res_found;
   logic [7:0] res_inp;
   logic [8:0] match_cnt;

   modport slave (
      input  tgt_valid, tgt_code, tgt_cont, abort, res_ready,
      output tgt_ready, res_valid, res_found, res_inp, match_cnt
   );

   modport master (
      output tgt_valid, tgt_code, tgt_cont, abort, res_ready,
      input  tgt_ready, res_valid, res_found, res_inp, match_cnt
   );
endinterface

// File: rtl/dtc_inverse_search.sv
// Inverse search of the 8-bit classifier F: finds the first input x with F(x) == target.
// Optional macro DTC_INV_COUNT_EN: sweep all remaining candidates and count matches.
//
// state  | meaning
// IDLE   | waiting for a target, tgt_ready high
// SEARCH | one candidate evaluated per clock
// REPORT | result held until res_ready
module dtc_inverse_search (
   input  logic                  clk,
   input  logic                  rst_n,
   dtc_inverse_search_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] tgt_r;
   logic [7:0] cand;
   logic [7:0] last_inp;
   logic       empty_r;
   logic       res_found_r;
   logic [7:0] res_inp_r;
   logic       hit;

   function automatic logic [7:0] f_class(input logic [7:0] x);
      logic [7:0] y;
      if (!x[6]) begin
         if (!x[4]) y = x[0] ? 8'hEA : 8'hB8;
         else       y = x[1] ? 8'h0C : 8'hF0;
      end else begin
         if (!x[0]) y = x[1] ? 8'hCF : 8'h86;
         else       y = x[5] ? 8'h32 : 8'h51;
      end
      return y;
   endfunction

   assign hit = (f_class(cand) == tgt_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.tgt_valid) state_nxt = SEARCH;
         SEARCH: begin
            if (bus.abort)          state_nxt = IDLE;
            else if (empty_r)       state_nxt = REPORT;
            else if (cand == 8'hFF) state_nxt = REPORT;
`ifndef DTC_INV_COUNT_EN
            else if (hit)           state_nxt = REPORT;
`endif
         end
         REPORT:  if (bus.res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A resumed search past 0xFF is flagged empty so the counter never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_r       <= 8'h00;
         cand        <= 8'h00;
         last_inp    <= 8'hFF;
         empty_r     <= 1'b0;
         res_found_r <= 1'b0;
         res_inp_r   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (bus.tgt_valid) begin
                  tgt_r       <= bus.tgt_code;
                  cand        <= bus.tgt_cont ? last_inp + 8'd1 : 8'h00;
                  empty_r     <= bus.tgt_cont && (last_inp == 8'hFF);
                  res_found_r <= 1'b0;
                  res_inp_r   <= 8'hFF;
               end
            end
            SEARCH: begin
               if (!bus.abort && !empty_r) begin
                  if (hit && !res_found_r) begin
                     res_found_r <= 1'b1;
                     res_inp_r   <= cand;
                     last_inp    <= cand;
                  end
                  if (cand != 8'hFF) cand <= cand + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DTC_INV_COUNT_EN
   logic [8:0] cnt_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 9'd0;
      end else if (state == IDLE && bus.tgt_valid) begin
         cnt_r <= 9'd0;
      end else if (state == SEARCH && !bus.abort && !empty_r && hit) begin
         cnt_r <= cnt_r + 9'd1;
      end
   end

   assign bus.match_cnt = cnt_r;
`else
   assign bus.match_cnt = 9'd0;
`endif

   assign bus.tgt_ready = (state == IDLE);
   assign bus.res_valid = (state == REPORT);
   assign bus.res_found = res_found_r;
   assign bus.res_inp   = res_inp_r;

endmodule

// File: tb/tb_dtc_inverse_search.sv
// Self-checking bench for dtc_inverse_search against a sweep-based reference model.
// Expectations follow DTC_INV_COUNT_EN when it is defined for the build.
module tb_dtc_inverse_search;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   m_last = 255;

   dtc_inverse_search_if bus();

   dtc_inverse_search dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic int spec_f(input int x);
      bit b0, b1, b4, b5, b6;
      b0 = x[0]; b1 = x[1]; b4 = x[4]; b5 = x[5]; b6 = x[6];
      if (!b6 && !b4) return b0 ? 'hEA : 'hB8;
      if (!b6)        return b1 ? 'h0C : 'hF0;
      if (!b0)        return b1 ? 'hCF : 'h86;
      return b5 ? 'h32 : 'h51;
   endfunction

   // Sweep start..255; latency = edges after the accept edge until res_valid.
   task automatic ref_model(input int tgt, input bit cont, input int last,
                            output bit found, output int inp, output int cnt, output int lat);
      int start;
      start = cont ? last + 1 : 0;
      found = 0; inp = 255; cnt = 0;
      if (start > 255) begin
         lat = 1;
         return;
      end
      lat = 256 - start;
      for (int x = start; x < 256; x++) begin
         if (spec_f(x) == tgt) begin
            cnt++;
            if (!found) begin
               found = 1;
               inp   = x;
`ifndef DTC_INV_COUNT_EN
               lat   = x - start + 1;
`endif
            end
         end
      end
`ifndef DTC_INV_COUNT_EN
      cnt = 0;
`endif
   endtask

   task automatic run_search(input int code, input bit cont, input int hold, input string tag);
      bit e_found;
      int e_inp, e_cnt, e_lat, k;
      ref_model(code, cont, m_last, e_found, e_inp, e_cnt, e_lat);
      @(negedge clk);
      checks++;
      if (bus.tgt_ready !== 1'b1) begin
         errors++; $display("FAIL %s ready_before: got %0b exp 1", tag, bus.tgt_ready);
      end
      bus.tgt_valid = 1'b1; bus.tgt_code = 8'(code); bus.tgt_cont = cont; bus.res_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.tgt_valid = 1'b0;
      bus.tgt_cont  = 1'($urandom_range(0, 1));
      bus.tgt_code  = 8'($urandom);
      k = 0;
      while (k < 300) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (bus.res_valid === 1'b1) break;
      end
      checks++;
      if (k !== e_lat) begin
         errors++; $display("FAIL %s latency: got %0d exp %0d", tag, k, e_lat);
      end
      checks++;
      if (bus.res_found !== e_found) begin
         errors++; $display("FAIL %s found: got %0b exp %0b", tag, bus.res_found, e_found);
      end
      checks++;
      if (bus.res_inp !== 8'(e_inp)) begin
         errors++; $display("FAIL %s inp: got %0h exp %0h", tag, bus.res_inp, e_inp);
      end
      checks++;
      if (bus.match_cnt !== 9'(e_cnt)) begin
         errors++; $display("FAIL %s match_cnt: got %0d exp %0d", tag, bus.match_cnt, e_cnt);
      end
      checks++;
      if (bus.tgt_ready !== 1'b0) begin
         errors++; $display("FAIL %s ready_in_report: got %0b exp 0", tag, bus.tgt_ready);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if ({bus.res_valid, bus.tgt_ready, bus.res_found, bus.res_inp, bus.match_cnt}
             !== {1'b1, 1'b0, e_found, 8'(e_inp), 9'(e_cnt)}) begin
            errors++;
            $display("FAIL %s hold%0d: got v%0b r%0b f%0b i%0h c%0d exp v1 r0 f%0b i%0h c%0d",
                     tag, h, bus.res_valid, bus.tgt_ready, bus.res_found, bus.res_inp,
                     bus.match_cnt, e_found, e_inp, e_cnt);
         end
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
      checks++;
      if ({bus.tgt_ready, bus.res_valid} !== 2'b10) begin
         errors++; $display("FAIL %s release: got r%0b v%0b exp r1 v0", tag, bus.tgt_ready, bus.res_valid);
      end
      if (e_found) m_last = e_inp;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.tgt_valid = 1'b0; bus.tgt_code = 8'h00; bus.tgt_cont = 1'b0;
      bus.abort = 1'b0; bus.res_ready = 1'b0;
      #2;
      checks++;
      if ({bus.res_valid, bus.res_found, bus.res_inp, bus.match_cnt} !== 19'd0) begin
         errors++; $display("FAIL reset_outputs: got v%0b f%0b i%0h c%0d exp all 0",
                            bus.res_valid, bus.res_found, bus.res_inp, bus.match_cnt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.tgt_ready, bus.res_valid} !== 2'b10) begin
         errors++; $display("FAIL reset_release: got r%0b v%0b exp r1 v0", bus.tgt_ready, bus.res_valid);
      end
      m_last = 255;
   endtask

   task automatic test_cont_empty();
      run_search('hB8, 1'b1, 1, "cont_empty");
   endtask

   task automatic test_directed();
      run_search('hB8, 1'b0, 0, "b8_first");
      run_search('hB8, 1'b1, 5, "b8_cont_hold5");
      run_search('h0C, 1'b0, 0, "code_0c");
      run_search('h51, 1'b0, 2, "code_51");
      run_search('h00, 1'b0, 0, "not_found");
      run_search('h32, 1'b0, 0, "code_32");
   endtask

   task automatic test_abort(input int code, input int abort_edge, input string tag);
      @(negedge clk);
      bus.tgt_valid = 1'b1; bus.tgt_code = 8'(code); bus.tgt_cont = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.tgt_valid = 1'b0;
      for (int e = 1; e <= abort_edge; e++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL %s early_valid_e%0d: got %0b exp 0", tag, e, bus.res_valid);
         end
      end
      bus.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if ({bus.tgt_ready, bus.res_valid} !== 2'b10) begin
         errors++; $display("FAIL %s abort_idle: got r%0b v%0b exp r1 v0", tag, bus.tgt_ready, bus.res_valid);
      end
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL %s post_abort_valid: got %0b exp 0", tag, bus.res_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.tgt_valid = 1'b1; bus.tgt_code = 8'h00; bus.tgt_cont = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.tgt_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.tgt_ready, bus.res_valid, bus.res_found, bus.res_inp, bus.match_cnt} !== {1'b1, 19'd0}) begin
         errors++; $display("FAIL reset_mid: got r%0b v%0b f%0b i%0h c%0d exp r1 rest 0",
                            bus.tgt_ready, bus.res_valid, bus.res_found, bus.res_inp, bus.match_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 255;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.tgt_ready, bus.res_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_mid_after%0d: got r%0b v%0b exp r1 v0", i, bus.tgt_ready, bus.res_valid);
         end
      end
   endtask

   task automatic test_random();
      int codes[8] = '{'hEA, 'hB8, 'h0C, 'hF0, 'hCF, 'h86, 'h32, 'h51};
      int code;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 4) == 0) code = int'($urandom_range(0, 255));
         else                           code = codes[$urandom_range(0, 7)];
         run_search(code, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_cont_empty();
      test_directed();
      test_abort('h00, 10, "abort_e10");
      test_abort('h0C, 18, "abort_vs_match");
      run_search('hB8, 1'b1, 0, "cont_after_abort");
      test_reset_mid();
      test_cont_empty();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dtc_inverse_search.md
DTC_INVERSE_SEARCH -- requirements
Module: dtc_inverse_search

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- tgt_valid  in  1: target class code offered.
- tgt_ready  out  1: block accepts a target.
- tgt_code  in  8: target class code.
- tgt_cont  in  1: resume from last reported preimage + 1 instead of 0x00.
- abort  in  1: cancel a running search.
- res_valid  out  1: result available.
- res_ready  in  1: result consumed.
- res_found  out  1: a preimage was found.
- res_inp  out  8: first matching candidate, or 0xFF if none.
- match_cnt  out  9: number of matches in the sweep (see Configuration).
REQ-002 SHALL have no parameters; all widths are fixed.

Function
REQ-003 SHALL define classifier F(x), x[7:0], as follows:
- x6=0, x4=0: x0 ? 0xEA : 0xB8.
- x6=0, x4=1: x1 ? 0x0C : 0xF0.
- x6=1, x0=0: x1 ? 0xCF : 0x86.
- x6=1, x0=1: x5 ? 0x32 : 0x51.
REQ-004 SHALL implement the FSM states IDLE, SEARCH and REPORT; tgt_ready SHALL be 1 only in IDLE.
REQ-005 SHALL, on an accept edge E0 (tgt_valid & tgt_ready), latch tgt_code, load candidate c (0x00, or last_inp+1 when tgt_cont=1) and enter SEARCH.
REQ-006 SHALL evaluate exactly one candidate per cycle: the candidate held during edge Ek is compared as F(c)==target, then c increments.
REQ-007 SHALL, when a match is found at edge Ek, set res_found=1 and res_inp=c, update last_inp=c, and enter REPORT; res_valid SHALL be high from Ek onward (first match at candidate 0 gives res_valid after E1).
REQ-008 SHALL, when candidate 0xFF is evaluated without a match, set res_found=0 and res_inp=0xFF and enter REPORT; the candidate counter SHALL never wrap to 0x00 within one search.
REQ-009 SHALL, when tgt_cont=1 and last_inp=0xFF, report not-found immediately (one cycle) without wrapping.
REQ-010 SHALL hold res_valid and all res_* outputs stable until res_valid & res_ready, then return to IDLE on that edge.
REQ-011 SHALL, on abort=1 in SEARCH, return to IDLE on the next edge with no result and last_inp unchanged; abort SHALL be ignored in IDLE and REPORT.
REQ-012 SHALL give abort priority over a match that is detected on the same edge.

Reset
REQ-013 SHALL, while rst_n=0 (asynchronously), force: state=IDLE, tgt_ready=1 after release, res_valid=0, res_found=0, res_inp=0x00, match_cnt=0, last_inp=0xFF, candidate=0x00.
REQ-014 SHALL, on reset during SEARCH or REPORT, discard the search; no res_valid SHALL appear after release until a new accept.

Configuration
REQ-015 SHALL support the macro DTC_INV_COUNT_EN, behaving as follows:
- Defined: SEARCH always continues to candidate 0xFF; res_found and res_inp hold the first match; match_cnt counts all matches from the start candidate (0..256); REPORT is entered after candidate 0xFF is evaluated.
- Undefined: SEARCH stops at the first match per REQ-007; match_cnt is constant 0 and no counter logic is synthesized.

Verification
REQ-016 Target 0xB8, cont=0 → found=1, inp=0x00, res_valid after E1; with COUNT_EN, match_cnt=32 and res_valid after E256.
REQ-017 Target 0x0C → inp=0x12, res_valid after E19; target 0x51 → inp=0x41, res_valid after E66 (COUNT_EN off).
REQ-018 Target 0x00 → found=0, inp=0xFF, res_valid after E256, match_cnt=0.
REQ-019 0xB8 found at 0x00, then tgt_cont=1 with 0xB8 → inp=0x02; hold res_ready=0 for 5 cycles → outputs stable, tgt_ready=0.
REQ-020 Target 0x00, abort at E10 → IDLE at E11 with no res_valid; rst_n pulsed low mid-SEARCH → all outputs at reset values immediately.
